q_8_7_subtractor_gen: RTL and testbench

- Parametrised successor to the 8-bit start/rdy subtractor.
- Computes |A - B| and a sign flag using a digit-serial datapath that processes DIGIT bits per cycle, plus a final two's-complement correction step.
- Organised as a controller FSM plus a datapath holding operand registers RA and RB, a result register RC, and a borrow flop.
- Sits behind a start/rdy handshake and is used as a multi-cycle arithmetic unit.

---
 rtl/q_8_7_subtractor_gen.sv | 99 +++++++++
 tb/tb_q_8_7_subtractor_gen.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/q_8_7_subtractor_gen.sv
// Digit-serial |A - B| unit with sign flag behind a start/rdy handshake.
// Optional macro SUB_SIGNED_EN treats A/B as two's-complement (sign-extended operands).
module q_8_7_subtractor_gen #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] result,
   output logic             neg,
   output logic             rdy,
   output logic             busy
);
   localparam int NDIG = (WIDTH + DIGIT) / DIGIT;
   localparam int EW   = NDIG * DIGIT;
   localparam int CW   = $clog2(NDIG + 1);

   typedef enum logic [1:0] {S_IDLE, S_SUB, S_COMP, S_DONE} state_t;

   state_t           r_state, w_next;
   logic [EW-1:0]    r_ra, r_rb, r_rc;
   logic             r_borrow;
   logic [CW-1:0]    r_cnt;
   logic [DIGIT:0]   w_diff;
   logic [EW-1:0]    w_rc_shift, w_a_ext, w_b_ext;
   logic [WIDTH-1:0] w_mag_neg;
   logic             w_accept, w_last;

   assign w_accept  = start && (r_state == S_IDLE || r_state == S_DONE);
   assign w_last    = (r_cnt == CW'(NDIG - 1));
   assign w_diff    = {1'b0, r_ra[DIGIT-1:0]} - {1'b0, r_rb[DIGIT-1:0]}
                      - {{DIGIT{1'b0}}, r_borrow};
   // Low WIDTH bits of -RC equal the negation of RC's low WIDTH bits.
   assign w_mag_neg = -r_rc[WIDTH-1:0];

`ifdef SUB_SIGNED_EN
   assign w_a_ext = {{(EW-WIDTH){A[WIDTH-1]}}, A};
   assign w_b_ext = {{(EW-WIDTH){B[WIDTH-1]}}, B};
`else
   assign w_a_ext = {{(EW-WIDTH){1'b0}}, A};
   assign w_b_ext = {{(EW-WIDTH){1'b0}}, B};
`endif

   generate
      if (DIGIT == EW) begin : g_full
         assign w_rc_shift = w_diff[DIGIT-1:0];
      end else begin : g_part
         assign w_rc_shift = {w_diff[DIGIT-1:0], r_rc[EW-1:DIGIT]};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: if (start) w_next = S_SUB;
         S_SUB:          if (w_last) w_next = S_COMP;
         S_COMP:         w_next = S_DONE;
         default:        w_next = S_IDLE;
      endcase
   end

   assign busy = (r_state == S_SUB) || (r_state == S_COMP);
   assign rdy  = (r_state == S_DONE);

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_ra     <= '0;
         r_rb     <= '0;
         r_rc     <= '0;
         r_borrow <= 1'b0;
         r_cnt    <= '0;
         result   <= '0;
         neg      <= 1'b0;
      end else if (w_accept) begin
         r_ra     <= w_a_ext;
         r_rb     <= w_b_ext;
         r_rc     <= '0;
         r_borrow <= 1'b0;
         r_cnt    <= '0;
      end else if (r_state == S_SUB) begin
         r_ra     <= r_ra >> DIGIT;
         r_rb     <= r_rb >> DIGIT;
         r_rc     <= w_rc_shift;
         r_borrow <= w_diff[DIGIT];
         r_cnt    <= r_cnt + CW'(1);
      end else if (r_state == S_COMP) begin
         neg    <= r_rc[EW-1];
         result <= r_rc[EW-1] ? w_mag_neg : r_rc[WIDTH-1:0];
      end
   end
endmodule

// File: tb/tb_q_8_7_subtractor_gen.sv
// Bench for q_8_7_subtractor_gen: default, WIDTH=8/DIGIT=4 and WIDTH=16/DIGIT=5 instances.
module tb_q_8_7_subtractor_gen;
   logic        clk = 1'b0;
   logic        rst_b = 1'b0;
   logic        st0 = 0, st1 = 0, st2 = 0;
   logic [7:0]  a0 = 0, b0 = 0, a1 = 0, b1 = 0;
   logic [15:0] a2 = 0, b2 = 0;
   logic [7:0]  res0, res1;
   logic [15:0] res2;
   logic        neg0, neg1, neg2, rdy0, rdy1, rdy2, busy0, busy1, busy2;
   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   q_8_7_subtractor_gen d0 (.clk(clk), .rst_b(rst_b), .start(st0), .A(a0), .B(b0),
      .result(res0), .neg(neg0), .rdy(rdy0), .busy(busy0));
   q_8_7_subtractor_gen #(.WIDTH(8), .DIGIT(4)) d1 (.clk(clk), .rst_b(rst_b), .start(st1),
      .A(a1), .B(b1), .result(res1), .neg(neg1), .rdy(rdy1), .busy(busy1));
   q_8_7_subtractor_gen #(.WIDTH(16), .DIGIT(5)) d2 (.clk(clk), .rst_b(rst_b), .start(st2),
      .A(a2), .B(b2), .result(res2), .neg(neg2), .rdy(rdy2), .busy(busy2));

   typedef struct {
      logic [7:0] a, b, res;
      logic       neg;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Reference: plain integer difference of the operand values.
   function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 output logic [15:0] r, output logic n);
      longint sa, sb, d;
      sa = longint'(a);
      sb = longint'(b);
`ifdef SUB_SIGNED_EN
      if (a[w-1]) sa -= (64'sd1 <<< w);
      if (b[w-1]) sb -= (64'sd1 <<< w);
`endif
      d = sa - sb;
      n = (d < 0);
      if (n) d = -d;
      r = 16'(d);
   endfunction

   function automatic logic rdy_of(input int u);
      return (u == 0) ? rdy0 : (u == 1) ? rdy1 : rdy2;
   endfunction
   function automatic logic busy_of(input int u);
      return (u == 0) ? busy0 : (u == 1) ? busy1 : busy2;
   endfunction
   function automatic logic [15:0] res_of(input int u);
      return (u == 0) ? {8'h0, res0} : (u == 1) ? {8'h0, res1} : res2;
   endfunction
   function automatic logic neg_of(input int u);
      return (u == 0) ? neg0 : (u == 1) ? neg1 : neg2;
   endfunction
   function automatic int lat_of(input int u);
      return (u == 0) ? 10 : (u == 1) ? 4 : 5;
   endfunction

   task automatic drive(input int u, input logic [15:0] a, input logic [15:0] b, input logic s);
      case (u)
         0:       begin a0 = a[7:0]; b0 = b[7:0]; st0 = s; end
         1:       begin a1 = a[7:0]; b1 = b[7:0]; st1 = s; end
         default: begin a2 = a;      b2 = b;      st2 = s; end
      endcase
   endtask

   // After an accepting edge, count edges until rdy is seen (sampled on negedges).
   task automatic wait_rdy(input int u, input int hold, input logic [15:0] a,
                           input logic [15:0] b, input string nm, output int n);
      n = 0;
      forever begin
         @(negedge clk);
         if (n == 0) begin
            chk({nm, " busy_after_accept"}, 32'(busy_of(u)), 32'd1);
            chk({nm, " rdy_after_accept"}, 32'(rdy_of(u)), 32'd0);
         end
         if (n == hold) drive(u, a ^ 16'h5A5A, b ^ 16'hA5A5, 1'b0);
         if (rdy_of(u)) break;
         if (n > 60) begin
            chk({nm, " timeout"}, 32'(n), 32'(lat_of(u)));
            break;
         end
         @(posedge clk);
         n++;
      end
   endtask

   task automatic op(input int u, input logic [15:0] a, input logic [15:0] b,
                     input int hold, input logic [15:0] er, input logic en, input string nm);
      int n;
      @(negedge clk);
      drive(u, a, b, 1'b1);
      @(posedge clk);
      wait_rdy(u, hold, a, b, nm, n);
      chk({nm, " latency"}, 32'(n), 32'(lat_of(u)));
      chk({nm, " result"}, 32'(res_of(u)), 32'(er));
      chk({nm, " neg"}, 32'(neg_of(u)), 32'(en));
   endtask

   task automatic rand_op(input int u, input int w);
      logic [15:0] a, b, er, mask;
      logic en;
      mask = 16'((32'd1 << w) - 1);
      a = 16'($urandom) & mask;
      b = 16'($urandom) & mask;
      if ($urandom_range(0, 7) == 0) b = a;
      model(w, a, b, er, en);
      op(u, a, b, 0, er, en, $sformatf("rand u%0d %0h-%0h", u, a, b));
   endtask

   initial begin
      vec_t vt[5];
      logic [15:0] er;
      logic en;
      int n;
`ifdef SUB_SIGNED_EN
      vt[0] = '{8'h80, 8'h7F, 8'hFF, 1'b1};
      vt[1] = '{8'hFE, 8'h03, 8'h05, 1'b1};
      vt[2] = '{8'h03, 8'hFE, 8'h05, 1'b0};
      vt[3] = '{8'h7A, 8'h7A, 8'h00, 1'b0};
      vt[4] = '{8'h54, 8'h43, 8'h11, 1'b0};
`else
      vt[0] = '{8'h54, 8'h43, 8'h11, 1'b0};
      vt[1] = '{8'h43, 8'h54, 8'h11, 1'b1};
      vt[2] = '{8'h7A, 8'h7A, 8'h00, 1'b0};
      vt[3] = '{8'h00, 8'hFF, 8'hFF, 1'b1};
      vt[4] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
`endif
      repeat (3) @(negedge clk);
      chk("reset result", 32'(res0), 32'd0);
      chk("reset neg", 32'(neg0), 32'd0);
      chk("reset rdy", 32'(rdy0), 32'd0);
      chk("reset busy", 32'(busy0), 32'd0);
      rst_b = 1'b1;

      for (int i = 0; i < 5; i++)
         op(0, {8'h0, vt[i].a}, {8'h0, vt[i].b}, 0, {8'h0, vt[i].res}, vt[i].neg,
            $sformatf("vec%0d", i));

      // Other digit widths.
      op(1, 16'h0010, 16'h0001, 0, 16'h000F, 1'b0, "d4 10-01");
`ifdef SUB_SIGNED_EN
      op(2, 16'h0001, 16'hFFFF, 0, 16'h0002, 1'b0, "w16d5 1-FFFF");
`else
      op(2, 16'h0001, 16'hFFFF, 0, 16'hFFFE, 1'b1, "w16d5 1-FFFF");
`endif

      // start held high while busy: no restart.
      model(8, 16'h0033, 16'h0071, er, en);
      op(0, 16'h0033, 16'h0071, 3, er, en, "hold_busy");

      // Back-to-back with start held through S_DONE.
      @(negedge clk);
      drive(0, 16'h0054, 16'h0043, 1'b1);
      @(posedge clk);
      wait_rdy(0, 99, 16'h0054, 16'h0043, "b2b first", n);
      chk("b2b first latency", 32'(n), 32'd10);
      model(8, 16'h0054, 16'h0043, er, en);
      chk("b2b first result", 32'(res0), 32'(er[7:0]));
      a0 = 8'hC8; b0 = 8'h19;
      @(posedge clk);
      model(8, 16'h00C8, 16'h0019, er, en);
      wait_rdy(0, 0, 16'h00C8, 16'h0019, "b2b second", n);
      chk("b2b second latency", 32'(n), 32'd10);
      chk("b2b second result", 32'(res0), 32'(er[7:0]));
      chk("b2b second neg", 32'(neg0), 32'(en));

      // Asynchronous reset in the middle of S_SUB.
      @(negedge clk);
      drive(0, 16'h0000, 16'h00FF, 1'b1);
      @(posedge clk);
      @(negedge clk);
      st0 = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst_b = 1'b0;
      #1;
      chk("midreset result", 32'(res0), 32'd0);
      chk("midreset rdy", 32'(rdy0), 32'd0);
      chk("midreset busy", 32'(busy0), 32'd0);
      @(negedge clk);
      rst_b = 1'b1;
      model(8, 16'h0054, 16'h0043, er, en);
      op(0, 16'h0054, 16'h0043, 0, er, en, "after_reset");

      for (int i = 0; i < 20; i++) rand_op(0, 8);
      for (int i = 0; i < 10; i++) rand_op(1, 8);
      for (int i = 0; i < 10; i++) rand_op(2, 16);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
